// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing (hs/vs/de/x/y/frame_start) on pix_clk, started after a settled pll_lock; optional colour bars under VIDEO_TIMING_PATTERN_EN (adds rgb[23:0])
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP = 20,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1,
  parameter int LOCK_WAIT = 1024
) (
  input logic pix_clk,
  input logic rst,
  input logic pll_lock,
  output logic hs,
  output logic vs,
  output logic de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic frame_start,
  output logic running
`ifdef VIDEO_TIMING_PATTERN_EN
  ,
  output logic [23:0] rgb
`endif
);
  localparam logic [11:0] HA = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HT1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VT1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int SW = $clog2(LOCK_WAIT + 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(LOCK_WAIT - 1);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  state_t state, state_n;
  logic lock_m, lock_s;
  logic [SW-1:0] settle, settle_n;
  logic [11:0] h_cnt, v_cnt, h_n, v_n;
  logic act, h_end, v_end, de_d;
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      state <= WAIT_LOCK;
      settle <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
      state <= state_n;
      settle <= settle_n;
      h_cnt <= h_n;
      v_cnt <= v_n;
    end
  end
  assign h_end = h_cnt == HT1;
  assign v_end = v_cnt == VT1;
  always_comb begin
    state_n = state;
    settle_n = '0;
    h_n = '0;
    v_n = '0;
    case (state)
      WAIT_LOCK: state_n = lock_s ? SETTLE : WAIT_LOCK;
      SETTLE: begin
        state_n = !lock_s ? WAIT_LOCK : settle == SETTLE_END ? RUN : SETTLE;
        settle_n = (lock_s && settle != SETTLE_END) ? settle + 1'b1 : '0;
      end
      RUN: begin
        state_n = lock_s ? RUN : WAIT_LOCK;
        h_n = (!lock_s || h_end) ? '0 : h_cnt + 1'b1;
        v_n = !lock_s ? '0 : !h_end ? v_cnt : v_end ? '0 : v_cnt + 1'b1;
      end
      default: state_n = WAIT_LOCK;
    endcase
  end
  // Decode is registered, so outputs trail the counters (and the state) by one cycle.
  assign act = state == RUN;
  assign de_d = act && h_cnt < HA && v_cnt < VA;
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
      running <= 1'b0;
    end else begin
      hs <= (act && h_cnt >= HS0 && h_cnt < HS1) ? HS_POL : ~HS_POL;
      vs <= (act && v_cnt >= VS0 && v_cnt < VS1) ? VS_POL : ~VS_POL;
      de <= de_d;
      x <= de_d ? h_cnt : '0;
      y <= de_d ? v_cnt : '0;
      frame_start <= act && h_cnt == '0 && v_cnt == '0;
      running <= act;
    end
  end
`ifdef VIDEO_TIMING_PATTERN_EN
  localparam logic [11:0] BW = 12'((H_ACTIVE / 8) > 0 ? H_ACTIVE / 8 : 1);
  logic [11:0] bar_q;
  logic [2:0] bar;
  assign bar_q = h_cnt / BW;
  assign bar = bar_q > 12'd7 ? 3'd7 : bar_q[2:0];
  // Bar index bits map directly onto channels: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
  always_ff @(posedge pix_clk) begin
    if (rst) rgb <= '0;
    else rgb <= de_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;
  end
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen with small timing, both sync polarities side by side
module tb_video_timing_gen;
  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam int LW = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  logic pix_clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock = 1'b0;
  logic hs0, vs0, de0, fs0, run0, hs1, vs1, de1, fs1, run1;
  logic [11:0] x0, y0, x1, y1;
  logic [23:0] rgb0, rgb1;
  int total = 0;
  int pass = 0;
  bit m1 = 1'b0, m2 = 1'b0;
  int streak = 0;
  logic [52:0] sb0 [$];
  logic [52:0] sb1 [$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  always #5 pix_clk = ~pix_clk;
  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_ACTIVE(VA),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(LW)) u0 (
    .pix_clk(pix_clk), .rst(rst), .pll_lock(pll_lock), .hs(hs0), .vs(vs0), .de(de0),
    .x(x0), .y(y0), .frame_start(fs0), .running(run0)
`ifdef VIDEO_TIMING_PATTERN_EN
    , .rgb(rgb0)
`endif
  );
  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_ACTIVE(VA),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(LW)) u1 (
    .pix_clk(pix_clk), .rst(rst), .pll_lock(pll_lock), .hs(hs1), .vs(vs1), .de(de1),
    .x(x1), .y(y1), .frame_start(fs1), .running(run1)
`ifdef VIDEO_TIMING_PATTERN_EN
    , .rgb(rgb1)
`endif
  );
`ifndef VIDEO_TIMING_PATTERN_EN
  assign rgb0 = 24'h0;
  assign rgb1 = 24'h0;
`endif
  // Expected outputs after an edge: idle, or raster pixel n counted from the first visible pixel.
  function automatic logic [52:0] expv(input bit idle, input int n, input bit pol);
    int h, v;
    bit d, hsa, vsa;
    logic [23:0] c;
    if (idle) return {24'h0, 1'b0, 1'b0, 1'b0, ~pol, ~pol, 12'd0, 12'd0};
    h = n % HT;
    v = (n / HT) % VT;
    d = h < HA && v < VA;
    hsa = h >= HA + HFP && h < HA + HFP + HSY;
    vsa = v >= VA + VFP && v < VA + VFP + VSY;
    c = d ? bars[h] : 24'h0;
`ifndef VIDEO_TIMING_PATTERN_EN
    c = 24'h0;
`endif
    return {c, 1'b1, n % (HT * VT) == 0, d, pol ? hsa : !hsa, pol ? vsa : !vsa,
            d ? 12'(h) : 12'd0, d ? 12'(v) : 12'd0};
  endfunction
  // Outputs after an edge reflect how many consecutive synchronised-lock samples preceded it:
  // one to leave WAIT_LOCK, LOCK_WAIT in SETTLE, then pixel 0 appears.
  task automatic cyc(input logic l, input logic r);
    bit idle;
    logic [52:0] e0, e1;
    pll_lock = l;
    rst = r;
    idle = r || streak < LW + 1;
    sb0.push_back(expv(idle, streak - (LW + 1), 1'b1));
    sb1.push_back(expv(idle, streak - (LW + 1), 1'b0));
    @(posedge pix_clk);
    if (r) begin
      streak = 0;
      m1 = 0;
      m2 = 0;
    end else begin
      streak = m2 ? streak + 1 : 0;
      m2 = m1;
      m1 = l;
    end
    #1;
    e0 = sb0.pop_front();
    e1 = sb1.pop_front();
    total++;
    assert ({rgb0, run0, fs0, de0, hs0, vs0, x0, y0} === e0) pass++;
    else $error("FAIL pos_pol t=%0t got %h exp %h", $time, {rgb0, run0, fs0, de0, hs0, vs0, x0, y0}, e0);
    total++;
    assert ({rgb1, run1, fs1, de1, hs1, vs1, x1, y1} === e1) pass++;
    else $error("FAIL neg_pol t=%0t got %h exp %h", $time, {rgb1, run1, fs1, de1, hs1, vs1, x1, y1}, e1);
  endtask
  initial begin
    bit found;
    int k;
    repeat (5) cyc(1'b1, 1'b1);
    // First frame_start lands 2+4+1 edges after the first edge with rst low.
    repeat (LW + 4 + 2 * HT * VT) cyc(1'b1, 1'b0);
    found = 0;
    for (k = 0; k < 2 * HT * VT && !found; k++) begin
      if (streak >= LW + 1 && (streak - (LW + 1)) % (HT * VT) == 2 * HT + 5) found = 1;
      else cyc(1'b1, 1'b0);
    end
    total++;
    assert (found) pass++;
    else $error("FAIL reach_x5_y2 got %0d exp 1", found);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (LW + 8 + HT * VT) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      if (streak == 3) found = 1;
      else cyc(1'b1, 1'b0);
    end
    total++;
    assert (found) pass++;
    else $error("FAIL reach_settle2 got %0d exp 1", found);
    repeat (2) cyc(1'b0, 1'b0);
    repeat (LW + 40) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (LW + 30) cyc(1'b1, 1'b0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
